avl_burst_writer: RTL and testbench

AVL_BURST_WRITER -- requirements
Module: avl_burst_writer

---
 rtl/avl_wr_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/avl_burst_writer.sv | 111 +++++++++++
 tb/tb_avl_burst_writer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_wr_pkg.sv
// Shared types and constants for the Avalon-MM burst writer.
package avl_wr_pkg;

  localparam int unsigned DATA_W         = 128;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned BE_W           = 16;
  localparam int unsigned BYTES_PER_BEAT = 16;

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } wr_state_e;

  // Advance to the next burst address, folding back to base at the end of the window.
  function automatic logic [ADDR_W-1:0] next_burst_addr(
    input logic [ADDR_W-1:0] cur,
    input logic [ADDR_W-1:0] step,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] end_addr
  );
    logic [ADDR_W-1:0] nxt;
    nxt = cur + step;
    return (nxt == end_addr) ? base : nxt;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  // Guard against overflow/underflow regardless of what the caller requests.
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // Next-state for pointers, occupancy and the registered flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    full_d  = (cnt_d == CNT_W'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // Pointer/flag state; full resets high so upstream is held off until the first edge after release.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign occupancy = cnt_q;

endmodule

// File: rtl/avl_burst_writer.sv
// Buffers upstream words and writes them to Avalon-MM as fixed-length bursts.
module avl_burst_writer
  import avl_wr_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] ADDR_SPAN  = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic [7:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  output logic [31:0]       bursts_done
);

  localparam int unsigned       OCC_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned       BEAT_W      = $clog2(BURST_LEN) + 1;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BYTES_PER_BEAT);
  // May wrap to 0 when the window ends at the top of the address space; equality still works.
  localparam logic [ADDR_W-1:0] ADDR_END    = BASE_ADDR + ADDR_SPAN;

  wr_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       done_q, done_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [OCC_W-1:0]  occupancy;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .areset    (areset),
    .push      (fifo_push),
    .wdata     (in_data),
    .pop       (fifo_pop),
    .rdata     (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  // Burst sequencing: start only with a full burst buffered, pop one entry per accepted beat.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    done_d    = done_q;
    avm_write = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state_q)
      StIdle: begin
        beat_d = '0;
        if (!fifo_empty && (occupancy >= OCC_W'(BURST_LEN))) begin
          state_d = StBurst;
        end
      end
      StBurst: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) begin
          fifo_pop = 1'b1;
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            state_d = StIdle;
            beat_d  = '0;
            done_d  = done_q + 32'd1;
            addr_d  = next_burst_addr(addr_q, BURST_BYTES, BASE_ADDR, ADDR_END);
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      addr_q  <= BASE_ADDR;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_writedata  = avm_write ? fifo_rdata : '0;
  assign avm_byteenable = '1;
  assign avm_burstcount = 8'(BURST_LEN);
  assign bursts_done    = done_q;

endmodule

// File: tb/tb_avl_burst_writer.sv
// Directed bench for avl_burst_writer with a data scoreboard and an address model.
module tb_avl_burst_writer;

  localparam int unsigned BL   = 8;
  localparam logic [31:0] SPAN = 32'h0000_0100;

  logic         clk;
  logic         areset;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic [31:0]  avm_address;
  logic         avm_write;
  logic [127:0] avm_writedata;
  logic [15:0]  avm_byteenable;
  logic [7:0]   avm_burstcount;
  logic         avm_waitrequest;
  logic [31:0]  bursts_done;

  int compared   = 0;
  int mismatched = 0;
  int n_accepted = 0;
  int beat_count = 0;

  logic [127:0] q[$];
  logic [31:0]  exp_addr   = 32'h0;
  int           beat_idx   = 0;
  int           exp_bursts = 0;

  avl_burst_writer #(
    .BURST_LEN  (BL),
    .FIFO_DEPTH (16),
    .BASE_ADDR  (32'h0000_0000),
    .ADDR_SPAN  (SPAN)
  ) dut (
    .clk             (clk),
    .areset          (areset),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_burstcount  (avm_burstcount),
    .avm_waitrequest (avm_waitrequest),
    .bursts_done     (bursts_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one word and wait (bounded) until it is taken; the accepted word joins the scoreboard.
  task automatic send_word(input logic [127:0] d);
    int   waited = 0;
    logic acc    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (acc) begin
      q.push_back(d);
      n_accepted++;
    end
    check("send_timeout", 128'(acc), 128'(1));
  endtask

  task automatic drain();
    int   waited = 0;
    logic stuck;
    while ((q.size() != 0 || avm_write) && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    stuck = (q.size() != 0 || avm_write);
    check("drain_timeout", 128'(stuck), 128'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Beat monitor: every presented beat must match the scoreboard head and the modelled address.
  always @(negedge clk) begin
    if (areset) begin
      exp_addr   = 32'h0;
      beat_idx   = 0;
      exp_bursts = 0;
    end else if (avm_write) begin
      check("byteenable", 128'(avm_byteenable), 128'(16'hFFFF));
      check("burstcount", 128'(avm_burstcount), 128'(BL));
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL extra_beat: observed data=%0h expected no beat", avm_writedata);
      end else begin
        check("beat_addr", 128'(avm_address), 128'(exp_addr));
        check("beat_data", avm_writedata, q[0]);
        if (!avm_waitrequest) begin
          void'(q.pop_front());
          beat_count++;
          beat_idx++;
          if (beat_idx == BL) begin
            beat_idx = 0;
            exp_bursts++;
            exp_addr = exp_addr + 32'h80;
            if (exp_addr == SPAN) exp_addr = 32'h0;
          end
        end
      end
    end
  end

  initial begin
    int   beats_before;
    logic found;

    areset          = 1'b1;
    in_valid        = 1'b0;
    in_data         = '0;
    avm_waitrequest = 1'b0;

    // Reset values and first-edge ready.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_avm_write", 128'(avm_write), 128'(0));
    check("rst_writedata", avm_writedata, 128'(0));
    check("rst_address", 128'(avm_address), 128'(0));
    check("rst_bursts_done", 128'(bursts_done), 128'(0));
    areset = 1'b0;
    #1;
    check("ready_before_edge", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    check("ready_after_edge", 128'(in_ready), 128'(1));

    // Two back-to-back bursts of 0..15.
    for (int i = 0; i < 16; i++) send_word(128'(i));
    drain();
    check("two_bursts_done", 128'(bursts_done), 128'(2));

    // Seven words must not start a burst; the eighth must.
    for (int i = 16; i < 23; i++) send_word(128'(i));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("partial_no_write", 128'(avm_write), 128'(0));
    end
    send_word(128'(23));
    found = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      if (avm_write) begin
        found = 1'b1;
        break;
      end
    end
    check("burst_start_latency", 128'(found), 128'(1));
    drain();
    check("wrap_bursts_done", 128'(bursts_done), 128'(3));

    // Stall on cycles 3-6 of a burst.
    beats_before = beat_count;
    fork
      begin
        for (int i = 100; i < 108; i++) send_word(128'(i));
      end
      begin
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
          @(posedge clk);
          #1;
          if (avm_write) begin
            found = 1'b1;
            break;
          end
        end
        check("stall_burst_seen", 128'(found), 128'(1));
        repeat (2) @(posedge clk);
        #1;
        avm_waitrequest = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
      end
    join
    drain();
    check("stall_beat_total", 128'(beat_count - beats_before), 128'(8));
    check("stall_bursts_done", 128'(bursts_done), 128'(4));

    // Long stall with continuous input: buffer fills, then everything drains intact.
    avm_waitrequest = 1'b1;
    n_accepted      = 0;
    fork
      begin
        for (int i = 200; i < 232; i++) send_word(128'(i));
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        check("fill_accepted", 128'(n_accepted), 128'(16));
        check("fill_in_ready", 128'(in_ready), 128'(0));
        check("fill_write_held", 128'(avm_write), 128'(1));
        avm_waitrequest = 1'b0;
      end
    join
    drain();
    check("fill_bursts_done", 128'(bursts_done), 128'(8));

    // Reset after beat 4 of a burst.
    avm_waitrequest = 1'b1;
    for (int i = 300; i < 308; i++) send_word(128'(i));
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (avm_write) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("rst_burst_seen", 128'(found), 128'(1));
    avm_waitrequest = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    avm_waitrequest = 1'b1;
    areset          = 1'b1;
    q.delete();
    #1;
    check("midrst_avm_write", 128'(avm_write), 128'(0));
    check("midrst_writedata", avm_writedata, 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    check("midrst_address", 128'(avm_address), 128'(0));
    check("midrst_bursts_done", 128'(bursts_done), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    check("midrst_write_held_low", 128'(avm_write), 128'(0));
    areset          = 1'b0;
    avm_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", 128'(in_ready), 128'(1));
    check("post_rst_no_resume", 128'(avm_write), 128'(0));
    for (int i = 500; i < 508; i++) send_word(128'(i));
    drain();
    check("post_rst_bursts_done", 128'(bursts_done), 128'(1));
    check("post_rst_next_addr", 128'(avm_address), 128'(32'h80));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
